// File: rtl/ls_unit.sv
// Memory-access stage: takes one EX result, performs at most one load/store
// on the data-memory port and hands the writeback payload to WB.
module ls_unit #(
    parameter int XLEN   = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m_valid_i,
    output logic              m_ready_o,
    input  logic              m_wenReg_i,
    input  logic [4:0]        m_rd_i,
    input  logic [XLEN-1:0]   m_res_i,
    input  logic [XLEN-1:0]   m_src2_i,
    input  logic              m_wenMem_i,
    input  logic              m_renMem_i,
    input  logic [MASK_W-1:0] m_mask_i,
    input  logic              m_is_load_signed_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [XLEN-1:0]   mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_wdata_o,
    output logic [MASK_W-1:0] mem_req_wstrb_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [XLEN-1:0]   mem_resp_rdata_i,
    input  logic              mem_resp_err_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic              w_wenReg_o,
    output logic [4:0]        w_rd_o,
    output logic [XLEN-1:0]   w_data_o,
    output logic              w_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_e;

    state_e              state_q, state_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     sdata_q, sdata_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                sgn_q, sgn_d;
    logic                store_q, store_d;
    logic                wen_q, wen_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     data_q, data_d;

    logic                mem_op;
    logic                misaligned;
    logic [XLEN-1:0]     lane;
    logic [XLEN-1:0]     load_val;

    assign mem_op     = m_wenMem_i | m_renMem_i;
    // Half needs addr[0]=0; word additionally needs addr[1]=0.
    assign misaligned = (m_mask_i[1] & m_res_i[0])
                      | (m_mask_i[3] & m_res_i[1]);

    assign lane = mem_resp_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = lane;
        if (!mask_q[3] && mask_q[1])
            load_val = {{(XLEN-16){sgn_q & lane[15]}}, lane[15:0]};
        else if (!mask_q[3])
            load_val = {{(XLEN-8){sgn_q & lane[7]}}, lane[7:0]};
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        mask_d  = mask_q;
        sgn_d   = sgn_q;
        store_d = store_q;
        wen_d   = wen_q;
        err_d   = err_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (m_valid_i) begin
                    rd_d    = m_rd_i;
                    addr_d  = m_res_i;
                    sdata_d = m_src2_i;
                    mask_d  = m_mask_i;
                    sgn_d   = m_is_load_signed_i;
                    store_d = m_wenMem_i;
                    data_d  = m_res_i;
                    wen_d   = m_wenReg_i & ~m_wenMem_i;
                    err_d   = 1'b0;
                    if (!mem_op) begin
                        state_d = OUT;
                    end else if (misaligned) begin
                        state_d = OUT;
                        err_d   = 1'b1;
                        wen_d   = 1'b0;
                        data_d  = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready_i)
                    state_d = RESP;
            end
            RESP: begin
                if (mem_resp_valid_i) begin
                    state_d = OUT;
                    if (mem_resp_err_i) begin
                        err_d  = 1'b1;
                        wen_d  = 1'b0;
                        data_d = '0;
                    end else if (!store_q) begin
                        data_d = load_val;
                    end
                end
            end
            OUT: begin
                if (w_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rd_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            mask_q  <= '0;
            sgn_q   <= 1'b0;
            store_q <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            mask_q  <= mask_d;
            sgn_q   <= sgn_d;
            store_q <= store_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign m_ready_o        = (state_q == IDLE);
    assign mem_req_valid_o  = (state_q == REQ);
    assign mem_resp_ready_o = (state_q == RESP);
    assign w_valid_o        = (state_q == OUT);

    assign mem_req_we_o    = store_q;
    assign mem_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_req_wdata_o = sdata_q << {addr_q[1:0], 3'b000};
    assign mem_req_wstrb_o = store_q ? (mask_q << addr_q[1:0]) : '0;

    assign w_wenReg_o = wen_q;
    assign w_rd_o     = rd_q;
    assign w_data_o   = data_q;
    assign w_err_o    = err_q;

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: directed cases plus randomized transactions
// checked against an arithmetic model of the access rules.
module tb_ls_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_valid_i;
    logic        m_ready_o;
    logic        m_wenReg_i;
    logic [4:0]  m_rd_i;
    logic [31:0] m_res_i;
    logic [31:0] m_src2_i;
    logic        m_wenMem_i;
    logic        m_renMem_i;
    logic [3:0]  m_mask_i;
    logic        m_is_load_signed_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_resp_rdata_i;
    logic        mem_resp_err_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic        w_wenReg_o;
    logic [4:0]  w_rd_o;
    logic [31:0] w_data_o;
    logic        w_err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_data;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;
    logic [31:0] last_addr;

    ls_unit #(.XLEN(32), .MASK_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
        .m_wenReg_i(m_wenReg_i), .m_rd_i(m_rd_i),
        .m_res_i(m_res_i), .m_src2_i(m_src2_i),
        .m_wenMem_i(m_wenMem_i), .m_renMem_i(m_renMem_i),
        .m_mask_i(m_mask_i), .m_is_load_signed_i(m_is_load_signed_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_rdata_i(mem_resp_rdata_i), .mem_resp_err_i(mem_resp_err_i),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .w_wenReg_o(w_wenReg_o), .w_rd_o(w_rd_o),
        .w_data_o(w_data_o), .w_err_o(w_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // op: 0 alu, 1 load, 2 store
    task automatic model(input int op, input logic [31:0] addr,
                         input logic [31:0] src2, input logic [31:0] res,
                         input logic [3:0] mask, input logic sgn,
                         input logic wen, input logic [31:0] rdata,
                         input logic berr, output logic mis,
                         output logic [31:0] e_wdata,
                         output logic [3:0] e_wstrb,
                         output logic [31:0] e_data,
                         output logic e_wen, output logic e_err);
        int size, off;
        longint lanev, full;
        size = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
        off = int'(addr % 4);
        mis = (op != 0) && (off % size != 0);
        full = longint'(src2) << (8 * off);
        e_wdata = full[31:0];
        full = ((longint'(1) << size) - 1) << off;
        e_wstrb = (op == 2) ? full[3:0] : 4'b0000;
        e_data = res;
        e_wen = wen;
        e_err = 1'b0;
        if (op == 0) begin
        end else if (mis || berr) begin
            e_err = 1'b1;
            e_wen = 1'b0;
            e_data = 32'h0;
        end else if (op == 2) begin
            e_wen = 1'b0;
        end else begin
            lanev = (longint'(rdata) >> (8 * off))
                  & ((longint'(1) << (8 * size)) - 1);
            if (sgn && ((lanev >> (8 * size - 1)) & 1) == 1)
                lanev = lanev - (longint'(1) << (8 * size));
            e_data = lanev[31:0];
        end
    endtask

    task automatic run_txn(input int op, input logic [31:0] addr,
                           input logic [31:0] src2, input logic [3:0] mask,
                           input logic sgn, input logic wen,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic berr, input int req_wait,
                           input int resp_wait, input int w_wait);
        logic mis, e_wen, e_err;
        logic [31:0] e_wdata, e_data;
        logic [3:0] e_wstrb;
        model(op, addr, src2, addr, mask, sgn, wen, rdata, berr,
              mis, e_wdata, e_wstrb, e_data, e_wen, e_err);
        chk("m_ready_idle", 32'(m_ready_o), 32'd1);
        m_valid_i = 1'b1;
        m_wenReg_i = wen;
        m_rd_i = rd;
        m_res_i = addr;
        m_src2_i = src2;
        m_wenMem_i = (op == 2);
        m_renMem_i = (op == 1);
        m_mask_i = mask;
        m_is_load_signed_i = sgn;
        @(negedge clk_i);
        m_valid_i = 1'b0;
        m_res_i = $urandom;
        m_src2_i = $urandom;
        if (op != 0 && !mis) begin
            for (int k = 0; k <= req_wait; k++) begin
                chk("req_valid", 32'(mem_req_valid_o), 32'd1);
                chk("req_addr", mem_req_addr_o, {addr[31:2], 2'b00});
                chk("req_we", 32'(mem_req_we_o), 32'(op == 2));
                chk("req_wstrb", 32'(mem_req_wstrb_o), 32'(e_wstrb));
                if (op == 2)
                    chk("req_wdata", mem_req_wdata_o, e_wdata);
                chk("m_ready_busy", 32'(m_ready_o), 32'd0);
                last_wstrb = mem_req_wstrb_o;
                last_wdata = mem_req_wdata_o;
                last_addr = mem_req_addr_o;
                mem_req_ready_i = (k == req_wait);
                @(negedge clk_i);
            end
            mem_req_ready_i = 1'b0;
            chk("req_no_dup", 32'(mem_req_valid_o), 32'd0);
            for (int k = 0; k <= resp_wait; k++) begin
                chk("resp_ready", 32'(mem_resp_ready_o), 32'd1);
                mem_resp_valid_i = (k == resp_wait);
                mem_resp_rdata_i = rdata;
                mem_resp_err_i = berr;
                @(negedge clk_i);
            end
            mem_resp_valid_i = 1'b0;
            mem_resp_err_i = 1'b0;
            mem_resp_rdata_i = $urandom;
        end else begin
            chk("no_req", 32'(mem_req_valid_o), 32'd0);
        end
        for (int k = 0; k <= w_wait; k++) begin
            chk("w_valid", 32'(w_valid_o), 32'd1);
            chk("w_rd", 32'(w_rd_o), 32'(rd));
            chk("w_wen", 32'(w_wenReg_o), 32'(e_wen));
            chk("w_err", 32'(w_err_o), 32'(e_err));
            if (!mis)
                chk("w_data", w_data_o, e_data);
            chk("m_ready_out", 32'(m_ready_o), 32'd0);
            last_data = w_data_o;
            w_ready_i = (k == w_wait);
            @(negedge clk_i);
        end
        w_ready_i = 1'b0;
        chk("w_valid_drop", 32'(w_valid_o), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_m_ready"}, 32'(m_ready_o), 32'd1);
        chk({tag, "_req_valid"}, 32'(mem_req_valid_o), 32'd0);
        chk({tag, "_resp_ready"}, 32'(mem_resp_ready_o), 32'd0);
        chk({tag, "_w_valid"}, 32'(w_valid_o), 32'd0);
        chk({tag, "_w_err"}, 32'(w_err_o), 32'd0);
        chk({tag, "_w_wen"}, 32'(w_wenReg_o), 32'd0);
        chk({tag, "_w_data"}, w_data_o, 32'd0);
    endtask

    initial begin
        int op;
        logic [3:0] mask;
        logic [3:0] masks [3];
        masks[0] = 4'b0001;
        masks[1] = 4'b0011;
        masks[2] = 4'b1111;
        rst_i = 1'b1;
        m_valid_i = 1'b0;
        m_wenReg_i = 1'b0;
        m_rd_i = '0;
        m_res_i = '0;
        m_src2_i = '0;
        m_wenMem_i = 1'b0;
        m_renMem_i = 1'b0;
        m_mask_i = '0;
        m_is_load_signed_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_rdata_i = '0;
        mem_resp_err_i = 1'b0;
        w_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk_reset_outs("rst");

        run_txn(0, 32'h0000_1234, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd5,
                32'h0, 1'b0, 0, 0, 0);
        chk("alu_data", last_data, 32'h0000_1234);

        run_txn(1, 32'h8000_0003, 32'h0, 4'b0001, 1'b1, 1'b1, 5'd7,
                32'h80AA_BBCC, 1'b0, 0, 0, 0);
        chk("lb_addr", last_addr, 32'h8000_0000);
        chk("lb_wstrb", 32'(last_wstrb), 32'd0);
        chk("lb_data", last_data, 32'hFFFF_FF80);

        run_txn(2, 32'h8000_0002, 32'h0000_BEEF, 4'b0011, 1'b0, 1'b0,
                5'd0, 32'h0, 1'b0, 0, 0, 0);
        chk("sh_wdata", last_wdata, 32'hBEEF_0000);
        chk("sh_wstrb", 32'(last_wstrb), 32'b1100);

        run_txn(2, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1,
                5'd9, 32'h0, 1'b0, 3, 1, 2);
        run_txn(1, 32'h0000_0042, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd3,
                32'h0, 1'b0, 0, 0, 0);
        run_txn(1, 32'h0000_0040, 32'h0, 4'b1111, 1'b0, 1'b1, 5'd4,
                32'h1234_5678, 1'b1, 0, 2, 0);
        chk("berr_data", last_data, 32'h0);

        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 2));
            mask = masks[$urandom_range(0, 2)];
            run_txn(op, $urandom, $urandom, mask, 1'($urandom),
                    1'($urandom), 5'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        // Reset while waiting for a load response.
        m_valid_i = 1'b1;
        m_wenReg_i = 1'b1;
        m_rd_i = 5'd11;
        m_res_i = 32'h0000_0200;
        m_wenMem_i = 1'b0;
        m_renMem_i = 1'b1;
        m_mask_i = 4'b1111;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        m_valid_i = 1'b0;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        chk("abort_in_resp", 32'(mem_resp_ready_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk_reset_outs("mid_rst");
        mem_resp_valid_i = 1'b1;
        mem_resp_rdata_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("late_resp_w_valid", 32'(w_valid_o), 32'd0);
        end
        mem_resp_valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ls_unit.md
Name: ls_unit

Overview:
Memory-access (LS) stage controller. It is the consumer end of the EX->LS pipeline register: it takes the registered EX results under a valid/ready handshake and performs at most one load or store per instruction on a simple request/response data-memory port. It then delivers the writeback payload to the WB stage under its own valid/ready handshake. One instruction in flight; no bypass of the handshake.

Parameters:
XLEN, 32, data and address width
MASK_W, 4, byte-mask width (XLEN/8)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m_valid_i  in  1  EX->LS register holds a valid instruction
m_ready_o  out  1  LS can accept (drives the pipe register's pout_ready)
m_wenReg_i  in  1  instruction writes rd
m_rd_i  in  5  destination register
m_res_i  in  XLEN  ALU result; the memory address for loads and stores
m_src2_i  in  XLEN  store data
m_wenMem_i  in  1  store
m_renMem_i  in  1  load
m_mask_i  in  MASK_W  access size: 0001 byte, 0011 half, 1111 word (lane-0 aligned)
m_is_load_signed_i  in  1  sign-extend load data
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_we_o  out  1  1 store, 0 load
mem_req_addr_o  out  XLEN  word-aligned address (addr[1:0] forced 0)
mem_req_wdata_o  out  XLEN  store data shifted to lane addr[1:0]
mem_req_wstrb_o  out  MASK_W  m_mask shifted left by addr[1:0]; 0 for loads
mem_resp_valid_i  in  1  response valid
mem_resp_ready_o  out  1  LS accepts response
mem_resp_rdata_i  in  XLEN  load data (full word)
mem_resp_err_i  in  1  bus error
w_valid_o  out  1  WB payload valid
w_ready_i  in  1  WB accepts
w_wenReg_o  out  1  register write enable (forced 0 on error)
w_rd_o  out  5  destination register
w_data_o  out  XLEN  load result, or m_res for non-memory ops and stores
w_err_o  out  1  misaligned or bus error

Behaviour:
- FSM states: IDLE, REQ, RESP, OUT. Reset (clk_i edge with rst_i=1) gives IDLE and clears all registered payload. Outputs after reset: m_ready_o=1, mem_req_valid_o=0, mem_resp_ready_o=0, w_valid_o=0, w_err_o=0, w_wenReg_o=0, w_data_o=0. A reset mid-transaction abandons it; any later response is ignored because mem_resp_ready_o=0 in IDLE.
- m_ready_o=1 only in IDLE. Accept = m_valid_i & m_ready_o. On accept, latch rd, wenReg, addr, store data, mask, signed, and op type.
- Accept, no memory op (wenMem=renMem=0): go to OUT with w_data=m_res. w_valid_o is asserted on the next cycle (1-cycle latency).
- Accept, misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to OUT with w_err=1 and w_wenReg=0. No memory request is issued.
- Accept, aligned memory op: go to REQ.
  - mem_req_valid_o=1 with stable address, data, and strobe until mem_req_ready_i. On handshake go to RESP.
- RESP: mem_resp_ready_o=1. On mem_resp_valid_i go to OUT.
  - Load: select lane = rdata >> (addr[1:0]*8). Byte or half is sign- or zero-extended per is_load_signed. Word passes through.
  - Store: w_data = m_res, w_wenReg = 0.
  - mem_resp_err_i=1: w_err=1, w_wenReg=0, w_data=0.
- Request and response may complete in the same cycle the previous state completes; there are no combinational valid->ready paths from mem_* inputs to mem_* outputs.
- OUT: w_valid_o=1 with stable payload until w_ready_i. On handshake go to IDLE. A new instruction is accepted only in the following cycle, so best-case throughput is 1 instruction per 2 cycles for non-memory ops.
- Payload registers change only on accept or load-response capture.

Test Plan:
1. ALU op: m_valid=1, wenReg=1, rd=5, res=0x1234 with w_ready=1. Required: w_valid high 1 cycle after accept with data 0x1234, rd=5, wenReg=1; m_ready returns high the cycle after.
2. Signed byte load: addr=0x8000_0003, mask=0001, signed=1, rdata=0x80AA_BBCC, memory ready with 0-wait. Required: wstrb=0 on the load, addr=0x8000_0000, w_data=0xFFFF_FF80.
3. Store half: addr=0x8000_0002, src2=0x0000_BEEF, mask=0011. Required: wdata=0xBEEF_0000, wstrb=1100, we=1, w_wenReg=0.
4. Backpressure: mem_req_ready low 3 cycles and w_ready low 2 cycles. Required: req valid and payload held stable throughout, m_ready_o stays 0, no duplicate request.
5. Misaligned word at 0x...02: no mem_req_valid_o pulse; w_err=1, w_wenReg=0. Bus error response on a load: w_err=1, w_data=0.
6. rst_i asserted while in RESP: next cycle state is IDLE with all outputs at reset values. A late mem_resp_valid produces no w_valid.
